operand_fifo_rc: RTL and testbench
==================================

# operand_fifo_rc

Parametrised first-word-fall-through (FWFT) FIFO that carries operand words between PEs of the Montgomery multiplier array. It replaces the vendor-macro FIFO with a portable register-array implementation. It adds occupancy reporting, almost-full back-pressure, sticky error flags, synchronous flush, and a recirculate mode. In recirculate mode the popped head word is written back to the tail, so an operand sequence can loop through a PE chain without reloading.

## Interface
- WIDTH, 17: data word width in bits, ≥1.
- DEPTH, 16: number of entries; power of two, ≥2.
- AF_LEVEL, DEPTH-2: almost_full_o asserts when count_o ≥ AF_LEVEL; 1 ≤ AF_LEVEL ≤ DEPTH.
- CW, $clog2(DEPTH+1): count_o width (derived, not overridden).

- clock_i  in  1  single clock; all state changes on the rising edge.
- reset_i  in  1  asynchronous, active-low reset.
- clear_i  in  1  synchronous flush.
- write_en_i  in  1  push data_i.
- read_en_i  in  1  pop head.
- recirc_i  in  1  with read_en_i, push the popped head to the tail.
- data_i  in  WIDTH  write data.
- data_o  out  WIDTH  head word (FWFT); 0 when empty.
- valid_o  out  1  head valid (= !empty_o).
- empty_o  out  1  count_o == 0.
- full_o  out  1  count_o == DEPTH.
- almost_full_o  out  1  count_o ≥ AF_LEVEL.
- count_o  out  CW  occupancy, 0..DEPTH.
- overflow_o  out  1  sticky: a write was rejected.
- underflow_o  out  1  sticky: a read was attempted while empty.

## Operation
- **Storage:** DEPTH×WIDTH register array, write pointer and read pointer of log2(DEPTH) bits, and a separate CW-bit counter. Pointers wrap modulo DEPTH naturally. The array itself is not reset.
- **Read:** read_en_i && !empty_o is a pop. The read pointer increments and the counter decrements.
- **Write:** write_en_i is a push if !full_o, or if full_o and a pop occurs in the same cycle. A push writes mem[wptr], increments the write pointer and increments the counter.
- **Simultaneous pop and push:** count is unchanged. This is legal both when full and when non-empty.
- **Recirculate (recirc_i && read_en_i && !empty_o):**
  - The head word is written to mem[wptr], and both pointers advance; count is unchanged.
  - write_en_i in the same cycle is dropped and sets overflow_o.
  - recirc_i without a valid pop has no effect.
- **Rejected write:** write_en_i while full with no pop is dropped; overflow_o is set.
- **Empty read:** read_en_i while empty is ignored; underflow_o is set. A write in the same cycle still proceeds.
- **clear_i:** overrides every other input. Pointers, counter, overflow_o and underflow_o all go to 0. Array contents are left stale.
- **data_o:** equals mem[rptr] when the FIFO is not empty, and is forced to 0 when empty.
- **Status outputs:** all are registered or derived from registered state. None has a combinational path from the *_i inputs.

## Timing
- **Reset (reset_i low, asynchronous):** pointers and counter go to 0, so empty_o=1 and full_o=0. All of almost_full_o, valid_o, overflow_o, underflow_o, count_o and data_o are 0.
- **Reset release:** the FIFO is operational on the first rising edge after reset_i goes high. Reset may be asserted mid-operation; all queued data is discarded.
- **Write to output latency:** a push at edge N into an empty FIFO gives data_o = word and valid_o=1 after edge N.
- **Pop:** the next word appears on data_o after the popping edge. Back-to-back pops every cycle are supported at full rate.
- **Status update:** count_o, full_o, empty_o and almost_full_o update on the same edge as the push or pop that changes them.
- **Throughput:** one push and one pop per cycle, sustained.
- **Recirculation:** a DEPTH-word loop returns to its original head after exactly DEPTH recirculating pops.

## Test plan
- **Reset and basic order:** reset, then push 0x00001, 0x00002, 0x00003 on consecutive cycles (WIDTH=17, DEPTH=16).
  - count_o steps 1, 2, 3.
  - data_o=0x00001 one cycle after the first push.
  - Three pops return 1, 2, 3, then empty_o=1 and data_o=0.
- **Fill to full:** push 16 words.
  - almost_full_o rises when count=14.
  - full_o rises when count=16.
  - A 17th write is dropped, overflow_o=1, and count_o stays 16.
  - With simultaneous push and pop while full: count_o stays 16 and order is preserved.
- **Underflow:** read_en_i on an empty FIFO gives underflow_o=1 and count_o=0.
  - In the same cycle, write_en_i with 0x1ABCD is accepted, and data_o=0x1ABCD on the next cycle.
- **Recirculate:** load 4 words A, B, C, D, then hold read_en_i=recirc_i=1 for 8 cycles.
  - data_o sequence is A B C D A B C D.
  - count_o stays 4 throughout.
  - A write_en_i pulse during this window sets overflow_o and leaves count_o at 4.
- **Wrap-around:** run 40 cycles of continuous push+pop with an incrementing pattern.
  - Output order matches input, with no loss across pointer wrap.
  - count_o stays constant.
- **Flush and asynchronous reset:** with 9 words queued and overflow_o=1, pulse clear_i for one cycle.
  - count_o=0, empty_o=1, overflow_o=0.
  - Refill 5 words, then assert reset_i low between edges: all outputs go to 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/operand_fifo_rc.sv
// operand_fifo_rc: FWFT register-array FIFO with occupancy, almost-full, sticky errors, flush and recirculate.
// Ports: clock_i/reset_i (async active-low), clear_i sync flush, write_en_i/data_i push,
// read_en_i pop, recirc_i loops the popped head back to the tail, data_o/valid_o head word,
// empty_o/full_o/almost_full_o/count_o occupancy, overflow_o/underflow_o sticky errors.
module operand_fifo_rc #(
    parameter int WIDTH    = 17,
    parameter int DEPTH    = 16,
    parameter int AF_LEVEL = DEPTH - 2,
    localparam int CW      = $clog2(DEPTH + 1)
) (
    input  logic             clock_i,
    input  logic             reset_i,
    input  logic             clear_i,
    input  logic             write_en_i,
    input  logic             read_en_i,
    input  logic             recirc_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] data_o,
    output logic             valid_o,
    output logic             empty_o,
    output logic             full_o,
    output logic             almost_full_o,
    output logic [CW-1:0]    count_o,
    output logic             overflow_o,
    output logic             underflow_o
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             overflow_q, overflow_d, underflow_q, underflow_d;
    logic             pop, recirc, push, wr;
    logic [WIDTH-1:0] wdata;
    assign empty_o       = count_q == '0;
    assign full_o        = count_q == CW'(DEPTH);
    assign almost_full_o = count_q >= CW'(AF_LEVEL);
    assign valid_o       = !empty_o;
    assign count_o       = count_q;
    assign overflow_o    = overflow_q;
    assign underflow_o   = underflow_q;
    assign data_o        = empty_o ? '0 : mem_q[rptr_q];
    always_comb begin
        pop    = read_en_i && !empty_o;
        recirc = pop && recirc_i;
        // recirculation owns the write port, so an external write in that cycle is dropped
        push   = write_en_i && !recirc && (!full_o || pop);
        wr     = recirc || push;
        wdata  = recirc ? mem_q[rptr_q] : data_i;
        wptr_d = clear_i ? '0 : (wr ? wptr_q + AW'(1) : wptr_q);
        rptr_d = clear_i ? '0 : (pop ? rptr_q + AW'(1) : rptr_q);
        count_d = clear_i ? '0 :
                  (wr && !pop) ? count_q + CW'(1) :
                  (pop && !wr) ? count_q - CW'(1) : count_q;
        overflow_d  = !clear_i && (overflow_q || (write_en_i && !push));
        underflow_d = !clear_i && (underflow_q || (read_en_i && empty_o));
    end
    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end
    always_ff @(posedge clock_i) begin
        if (wr && !clear_i) mem_q[wptr_q] <= wdata;
    end
endmodule

// File: tb/tb_operand_fifo_rc.sv
// tb_operand_fifo_rc: directed self-checking bench for operand_fifo_rc (WIDTH=17, DEPTH=16).
module tb_operand_fifo_rc;
    logic        clk = 1'b0;
    logic        reset_i = 1'b0;
    logic        clear_i = 1'b0, write_en_i = 1'b0, read_en_i = 1'b0, recirc_i = 1'b0;
    logic [16:0] data_i = '0;
    logic [16:0] data_o;
    logic        valid_o, empty_o, full_o, almost_full_o, overflow_o, underflow_o;
    logic [4:0]  count_o;
    int          n_checks = 0;
    int          n_fails = 0;
    operand_fifo_rc dut (
        .clock_i(clk), .reset_i(reset_i), .clear_i(clear_i),
        .write_en_i(write_en_i), .read_en_i(read_en_i), .recirc_i(recirc_i),
        .data_i(data_i), .data_o(data_o), .valid_o(valid_o), .empty_o(empty_o),
        .full_o(full_o), .almost_full_o(almost_full_o), .count_o(count_o),
        .overflow_o(overflow_o), .underflow_o(underflow_o)
    );
    always #5 clk = ~clk;
    task automatic step();
        @(posedge clk);
        #1;
        clear_i = 0; write_en_i = 0; read_en_i = 0; recirc_i = 0;
    endtask
    task automatic push(input logic [16:0] d);
        write_en_i = 1; data_i = d;
        step();
    endtask
    task automatic chk_zero_state(input string tag);
        n_checks++;
        if ({data_o, valid_o, empty_o, full_o, almost_full_o, count_o, overflow_o, underflow_o}
            !== {17'h0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0}) begin
            n_fails++;
            $display("FAIL %s: data=%h valid=%b empty=%b full=%b af=%b count=%0d ov=%b un=%b, required all 0 with empty=1",
                     tag, data_o, valid_o, empty_o, full_o, almost_full_o, count_o, overflow_o, underflow_o);
        end
    endtask
    task automatic test_reset();
        #2;
        chk_zero_state("reset");
        #10 reset_i = 1;
        step();
        chk_zero_state("after_release");
    endtask
    task automatic test_order();
        for (int i = 1; i <= 3; i++) begin
            push(17'(i));
            n_checks++;
            if (count_o !== 5'(i)) begin n_fails++; $display("FAIL order_count: got %0d want %0d", count_o, i); end
            n_checks++;
            if (data_o !== 17'h1) begin n_fails++; $display("FAIL order_head: got %h want 00001", data_o); end
        end
        for (int i = 1; i <= 3; i++) begin
            n_checks++;
            if (data_o !== 17'(i)) begin n_fails++; $display("FAIL order_pop: got %h want %h", data_o, 17'(i)); end
            read_en_i = 1;
            step();
        end
        chk_zero_state("order_drained");
    endtask
    task automatic test_fill();
        for (int i = 1; i <= 16; i++) begin
            push(17'h100 + 17'(i - 1));
            n_checks++;
            if ({count_o, almost_full_o, full_o} !== {5'(i), i >= 14, i == 16}) begin
                n_fails++;
                $display("FAIL fill_status: count=%0d af=%b full=%b, want count=%0d af=%b full=%b",
                         count_o, almost_full_o, full_o, i, i >= 14, i == 16);
            end
        end
        push(17'h1FFFF);
        n_checks++;
        if ({count_o, overflow_o, full_o} !== {5'd16, 1'b1, 1'b1}) begin
            n_fails++;
            $display("FAIL fill_overflow: count=%0d ov=%b full=%b want 16/1/1", count_o, overflow_o, full_o);
        end
        for (int i = 0; i < 2; i++) begin
            read_en_i = 1;
            push(17'h200 + 17'(i));
            n_checks++;
            if ({count_o, data_o} !== {5'd16, 17'h101 + 17'(i)}) begin
                n_fails++;
                $display("FAIL full_pushpop: count=%0d data=%h want 16/%h", count_o, data_o, 17'h101 + 17'(i));
            end
        end
        for (int i = 2; i < 18; i++) begin
            n_checks++;
            if (data_o !== (i < 16 ? 17'h100 + 17'(i) : 17'h200 + 17'(i - 16))) begin
                n_fails++;
                $display("FAIL fill_drain: got %h at index %0d", data_o, i);
            end
            read_en_i = 1;
            step();
        end
        n_checks++;
        if ({empty_o, overflow_o} !== 2'b11) begin n_fails++; $display("FAIL fill_empty: empty=%b ov=%b want 1/1", empty_o, overflow_o); end
        clear_i = 1;
        step();
    endtask
    task automatic test_underflow();
        read_en_i = 1;
        step();
        n_checks++;
        if ({underflow_o, count_o, empty_o} !== {1'b1, 5'd0, 1'b1}) begin
            n_fails++;
            $display("FAIL underflow: un=%b count=%0d empty=%b want 1/0/1", underflow_o, count_o, empty_o);
        end
        read_en_i = 1;
        push(17'h1ABCD);
        n_checks++;
        if ({data_o, count_o, valid_o} !== {17'h1ABCD, 5'd1, 1'b1}) begin
            n_fails++;
            $display("FAIL underflow_write: data=%h count=%0d valid=%b want 1abcd/1/1", data_o, count_o, valid_o);
        end
        read_en_i = 1;
        step();
        clear_i = 1;
        step();
        chk_zero_state("underflow_clear");
    endtask
    task automatic test_recirc();
        logic [16:0] seq [4] = '{17'h1000A, 17'h0000B, 17'h1C00C, 17'h0D0DD};
        for (int i = 0; i < 4; i++) push(seq[i]);
        for (int i = 0; i < 8; i++) begin
            n_checks++;
            if ({data_o, count_o} !== {seq[i % 4], 5'd4}) begin
                n_fails++;
                $display("FAIL recirc_seq[%0d]: data=%h count=%0d want %h/4", i, data_o, count_o, seq[i % 4]);
            end
            read_en_i = 1; recirc_i = 1;
            if (i == 3) begin write_en_i = 1; data_i = 17'h15555; end
            step();
            if (i == 3) begin
                n_checks++;
                if ({overflow_o, count_o} !== {1'b1, 5'd4}) begin
                    n_fails++;
                    $display("FAIL recirc_write: ov=%b count=%0d want 1/4", overflow_o, count_o);
                end
            end
        end
        n_checks++;
        if ({data_o, count_o} !== {seq[0], 5'd4}) begin
            n_fails++;
            $display("FAIL recirc_loop: data=%h count=%0d want %h/4", data_o, count_o, seq[0]);
        end
        recirc_i = 1;
        step();
        n_checks++;
        if ({data_o, count_o} !== {seq[0], 5'd4}) begin
            n_fails++;
            $display("FAIL recirc_no_pop: data=%h count=%0d want %h/4", data_o, count_o, seq[0]);
        end
        clear_i = 1;
        step();
    endtask
    task automatic test_wrap();
        for (int i = 0; i < 3; i++) push(17'h300 + 17'(i));
        for (int k = 0; k < 40; k++) begin
            n_checks++;
            if ({data_o, count_o} !== {17'h300 + 17'(k), 5'd3}) begin
                n_fails++;
                $display("FAIL wrap[%0d]: data=%h count=%0d want %h/3", k, data_o, count_o, 17'h300 + 17'(k));
            end
            read_en_i = 1;
            push(17'h303 + 17'(k));
        end
        clear_i = 1;
        step();
    endtask
    task automatic test_flush_reset();
        for (int i = 0; i < 9; i++) push(17'h40 + 17'(i));
        read_en_i = 1; recirc_i = 1;
        push(17'h0BAD);
        n_checks++;
        if ({count_o, overflow_o, data_o} !== {5'd9, 1'b1, 17'h41}) begin
            n_fails++;
            $display("FAIL flush_setup: count=%0d ov=%b data=%h want 9/1/41", count_o, overflow_o, data_o);
        end
        clear_i = 1;
        step();
        chk_zero_state("flush");
        for (int i = 0; i < 5; i++) push(17'h50 + 17'(i));
        n_checks++;
        if ({count_o, data_o} !== {5'd5, 17'h50}) begin
            n_fails++;
            $display("FAIL refill: count=%0d data=%h want 5/50", count_o, data_o);
        end
        #2 reset_i = 0;
        #1;
        chk_zero_state("async_reset");
        #3 reset_i = 1;
        step();
        chk_zero_state("post_reset");
    endtask
    initial begin
        test_reset();
        test_order();
        test_fill();
        test_underflow();
        test_recirc();
        test_wrap();
        test_flush_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
